// File: rtl/imem_load_ctrl_pkg.sv
// Shared definitions for the instruction-memory load controller.
// Holds the default geometry of the instruction memory, the FSM state
// encoding and the load-mode type used by imem_load_ctrl.
package imem_load_ctrl_pkg;

  // Default geometry of the instruction memory.
  localparam int ADDRESS_LEN      = 10;
  localparam int WORD_LEN         = 32;
  localparam int MEMORY_SIZE      = 1024;

  // Default post-load hold; the counter is wide enough for the 1..15 range.
  localparam int LDC_DRAIN_CYCLES = 4;
  localparam int DRAIN_CNT_W      = 4;

  // Controller states.
  localparam logic [1:0] LDC_BOOT  = 2'd0;
  localparam logic [1:0] LDC_LOAD  = 2'd1;
  localparam logic [1:0] LDC_DRAIN = 2'd2;
  localparam logic [1:0] LDC_RUN   = 2'd3;

  // Full loads hold the core in reset; patch loads only stall it.
  typedef enum logic {
    LD_MODE_FULL  = 1'b0,
    LD_MODE_PATCH = 1'b1
  } ld_mode_e;

endpackage

// File: rtl/load_addr_gen.sv
// Write-pointer / remaining-count generator for program loads.
//   clk, rst   : clock, asynchronous active-high reset
//   load_i     : capture base_i / count_i
//   base_i     : first word address of the load
//   count_i    : number of words in the load
//   advance_i  : one word accepted; bump pointer, drop remaining count
//   ptr_o      : address for the next word
//   empty_o    : no words remain
//   last_o     : exactly one word remains
module load_addr_gen #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] count_i,
  input  logic              advance_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              empty_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    ptr_d = ptr_q;
    rem_d = rem_q;
    if (load_i) begin
      ptr_d = base_i;
      rem_d = count_i;
    end else if (advance_i) begin
      ptr_d = ptr_q + 1'b1;
      rem_d = rem_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      rem_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      rem_q <= rem_d;
    end
  end

  assign ptr_o   = ptr_q;
  assign empty_o = (rem_q == '0);
  assign last_o  = (rem_q == ADDR_W'(1));

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller. Owns the single address port of the
// instruction memory: in LOAD it writes host words at the load pointer, in
// every other state it passes the PC fetch address through. Full loads keep
// the core in reset, patch loads (only from RUN) keep it stalled.
//   clk, rst                 : clock, asynchronous active-high reset
//   ld_start/ld_keep         : load request, patch-mode select
//   ld_base/ld_count         : load window, sampled with ld_start
//   ld_valid/ld_data/ld_ready: host word stream handshake
//   if_adr                   : fetch address from the PC
//   mem_adr/mem_we/mem_wdata : instruction memory port
//   core_rst/core_stall      : core control
//   busy/done/err            : status (LOAD|DRAIN, completion pulse, sticky range error)
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int ADDR_W       = ADDRESS_LEN,
  parameter int WORD_W       = WORD_LEN,
  parameter int MEM_DEPTH    = MEMORY_SIZE,
  parameter int DRAIN_CYCLES = LDC_DRAIN_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic              ld_keep,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W-1:0] ld_count,
  input  logic              ld_valid,
  input  logic [WORD_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] if_adr,
  output logic [ADDR_W-1:0] mem_adr,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              core_rst,
  output logic              core_stall,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0]      DEPTH_EXT  = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_INIT = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

  logic [1:0]             state_q, state_d;
  ld_mode_e               mode_q, mode_d;
  logic [DRAIN_CNT_W-1:0] drain_q, drain_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;

  logic [ADDR_W-1:0] ptr;
  logic              empty, last;
  logic              addr_load, accept;
  logic [ADDR_W:0]   range_end;
  logic              range_ok;

  // Sum at one extra bit so a window running past the top cannot wrap.
  assign range_end = {1'b0, ld_base} + {1'b0, ld_count};
  assign range_ok  = (range_end <= DEPTH_EXT);

  assign ld_ready = (state_q == LDC_LOAD) && !empty;
  assign accept   = ld_valid && ld_ready;

  load_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load_i    (addr_load),
    .base_i    (ld_base),
    .count_i   (ld_count),
    .advance_i (accept),
    .ptr_o     (ptr),
    .empty_o   (empty),
    .last_o    (last)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    drain_d   = drain_q;
    err_d     = err_q;
    done_d    = 1'b0;
    addr_load = 1'b0;
    case (state_q)
      LDC_BOOT, LDC_RUN: begin
        if (ld_start) begin
          if (!range_ok) begin
            err_d = 1'b1;
          end else begin
            err_d     = 1'b0;
            addr_load = 1'b1;
            state_d   = LDC_LOAD;
            // A patch only makes sense once a program is running.
            mode_d    = (state_q == LDC_RUN && ld_keep) ? LD_MODE_PATCH : LD_MODE_FULL;
          end
        end
      end
      LDC_LOAD: begin
        // A zero-length load still spends one cycle here before draining.
        if (empty || (accept && last)) begin
          state_d = LDC_DRAIN;
          drain_d = DRAIN_INIT;
        end
      end
      default: begin // LDC_DRAIN
        if (drain_q == '0) begin
          state_d = LDC_RUN;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LDC_BOOT;
      mode_q  <= LD_MODE_FULL;
      drain_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign busy       = (state_q == LDC_LOAD) || (state_q == LDC_DRAIN);
  assign core_rst   = (state_q == LDC_BOOT) || (busy && mode_q == LD_MODE_FULL);
  assign core_stall = busy && (mode_q == LD_MODE_PATCH);
  assign done       = done_q;
  assign err        = err_q;

  assign mem_we    = accept;
  assign mem_wdata = ld_data;
  assign mem_adr   = (state_q == LDC_LOAD) ? ptr : if_adr;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed, table-driven bench for imem_load_ctrl with a behavioural
// instruction memory fed by the controller's write port.
module tb_imem_load_ctrl;
  import imem_load_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_start, ld_keep, ld_valid;
  logic [9:0]  ld_base, ld_count, if_adr;
  logic [31:0] ld_data;
  logic        ld_ready, mem_we, core_rst, core_stall, busy, done, err;
  logic [9:0]  mem_adr;
  logic [31:0] mem_wdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imem_load_ctrl #(
    .ADDR_W       (10),
    .WORD_W       (32),
    .MEM_DEPTH    (1024),
    .DRAIN_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_start   (ld_start),
    .ld_keep    (ld_keep),
    .ld_base    (ld_base),
    .ld_count   (ld_count),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .if_adr     (if_adr),
    .mem_adr    (mem_adr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .core_rst   (core_rst),
    .core_stall (core_stall),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Instruction memory model, pre-filled with a recognisable pattern.
  logic [31:0] tmem [0:1023];
  initial for (int i = 0; i < 1024; i++) tmem[i] = 32'hA5A5_0000 | 32'(i);
  always @(posedge clk) if (mem_we) tmem[mem_adr] <= mem_wdata;

  function automatic logic [31:0] init_pat(input int a);
    return 32'hA5A5_0000 | 32'(a);
  endfunction

  typedef struct {
    logic        st, kp;
    logic [9:0]  base, cnt;
    logic        vld;
    logic [31:0] data;
    logic [9:0]  ifa;
    logic        chk_adr;
    logic [9:0]  adr;
    logic        rdy, we, crst, stall, bsy, dn, er;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic st, input logic kp, input logic [9:0] base,
                     input logic [9:0] cnt, input logic vld, input logic [31:0] data,
                     input logic [9:0] ifa, input logic chk_adr, input logic [9:0] adr,
                     input logic rdy, input logic we, input logic crst, input logic stall,
                     input logic bsy, input logic dn, input logic er);
    vec_t v;
    v.st = st; v.kp = kp; v.base = base; v.cnt = cnt; v.vld = vld; v.data = data;
    v.ifa = ifa; v.chk_adr = chk_adr; v.adr = adr; v.rdy = rdy; v.we = we;
    v.crst = crst; v.stall = stall; v.bsy = bsy; v.dn = dn; v.er = er;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ld_start = 1'b0; ld_keep = 1'b0; ld_base = '0; ld_count = '0;
    ld_valid = 1'b0; ld_data = '0;
  endtask

  initial begin
    // Columns: st kp base cnt vld data ifa | chk adr rdy we crst stall busy done err
    // Out-of-range request from BOOT (1022+3 > 1024): err, no load.
    row(1,0,1022,3, 0,0,           3,  1,3,    0,0,1,0,0,0,0);
    row(0,0,0,0,    0,0,           4,  1,4,    0,0,1,0,0,0,1);
    // Full load base=100 count=3 with one idle gap; in-range start clears err.
    row(1,0,100,3,  0,0,           7,  1,7,    0,0,1,0,0,0,1);
    row(0,0,0,0,    1,32'h8C010020,7,  1,100,  1,1,1,0,1,0,0);
    row(0,0,0,0,    0,0,           7,  0,0,    1,0,1,0,1,0,0);
    row(0,0,0,0,    1,32'h8C100021,7,  1,101,  1,1,1,0,1,0,0);
    row(0,0,0,0,    1,32'h00001024,7,  1,102,  1,1,1,0,1,0,0);
    row(0,0,0,0,    1,32'h00000BAD,8,  1,8,    0,0,1,0,1,0,0);
    row(0,0,0,0,    0,0,           9,  1,9,    0,0,1,0,1,0,0);
    row(0,0,0,0,    0,0,           9,  1,9,    0,0,1,0,1,0,0);
    row(0,0,0,0,    0,0,           9,  1,9,    0,0,1,0,1,0,0);
    row(0,0,0,0,    0,0,           55, 1,55,   0,0,0,0,0,1,0);
    row(0,0,0,0,    0,0,           56, 1,56,   0,0,0,0,0,0,0);
    // Zero-length full load from RUN: LOAD lasts one cycle, no writes.
    row(1,0,5,0,    0,0,           20, 1,20,   0,0,0,0,0,0,0);
    row(0,0,0,0,    1,32'h00001234,20, 0,0,    0,0,1,0,1,0,0);
    row(0,0,0,0,    0,0,           21, 1,21,   0,0,1,0,1,0,0);
    row(0,0,0,0,    0,0,           21, 1,21,   0,0,1,0,1,0,0);
    row(0,0,0,0,    0,0,           21, 1,21,   0,0,1,0,1,0,0);
    row(0,0,0,0,    0,0,           21, 1,21,   0,0,1,0,1,0,0);
    row(0,0,0,0,    0,0,           22, 1,22,   0,0,0,0,0,1,0);
    // Patch from RUN: base=10 count=1 word 0, core stalled not reset.
    row(1,1,10,1,   0,0,           30, 1,30,   0,0,0,0,0,0,0);
    row(0,0,0,0,    1,32'h00000000,30, 1,10,   1,1,0,1,1,0,0);
    row(0,0,0,0,    0,0,           31, 1,31,   0,0,0,1,1,0,0);
    row(0,0,0,0,    0,0,           31, 1,31,   0,0,0,1,1,0,0);
    row(0,0,0,0,    0,0,           31, 1,31,   0,0,0,1,1,0,0);
    row(0,0,0,0,    0,0,           31, 1,31,   0,0,0,1,1,0,0);
    row(0,0,0,0,    0,0,           32, 1,32,   0,0,0,0,0,1,0);
    // Full load ending exactly at the top (1021+3 == 1024); re-starts ignored.
    row(1,0,1021,3, 0,0,           40, 1,40,   0,0,0,0,0,0,0);
    row(1,1,0,1,    1,32'h000000A1,40, 1,1021, 1,1,1,0,1,0,0);
    row(0,0,0,0,    1,32'h000000A2,40, 1,1022, 1,1,1,0,1,0,0);
    row(0,0,0,0,    1,32'h000000A3,40, 1,1023, 1,1,1,0,1,0,0);
    row(1,0,1023,5, 0,0,           41, 1,41,   0,0,1,0,1,0,0);
    row(0,0,0,0,    0,0,           41, 1,41,   0,0,1,0,1,0,0);
    row(0,0,0,0,    0,0,           41, 1,41,   0,0,1,0,1,0,0);
    row(0,0,0,0,    0,0,           41, 1,41,   0,0,1,0,1,0,0);
    row(0,0,0,0,    0,0,           42, 1,42,   0,0,0,0,0,1,0);

    idle_inputs();
    if_adr = 10'd0;
    rst    = 1'b1;
    #2;
    check("reset.core_rst",   32'(core_rst),   32'd1);
    check("reset.core_stall", 32'(core_stall), 32'd0);
    check("reset.ld_ready",   32'(ld_ready),   32'd0);
    check("reset.mem_we",     32'(mem_we),     32'd0);
    check("reset.busy",       32'(busy),       32'd0);
    check("reset.done",       32'(done),       32'd0);
    check("reset.err",        32'(err),        32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      ld_start = vecs[i].st;  ld_keep  = vecs[i].kp;
      ld_base  = vecs[i].base; ld_count = vecs[i].cnt;
      ld_valid = vecs[i].vld; ld_data  = vecs[i].data;
      if_adr   = vecs[i].ifa;
      #1;
      check($sformatf("v%0d.ld_ready", i),   32'(ld_ready),   32'(vecs[i].rdy));
      check($sformatf("v%0d.mem_we", i),     32'(mem_we),     32'(vecs[i].we));
      if (vecs[i].chk_adr)
        check($sformatf("v%0d.mem_adr", i),  32'(mem_adr),    32'(vecs[i].adr));
      check($sformatf("v%0d.core_rst", i),   32'(core_rst),   32'(vecs[i].crst));
      check($sformatf("v%0d.core_stall", i), 32'(core_stall), 32'(vecs[i].stall));
      check($sformatf("v%0d.busy", i),       32'(busy),       32'(vecs[i].bsy));
      check($sformatf("v%0d.done", i),       32'(done),       32'(vecs[i].dn));
      check($sformatf("v%0d.err", i),        32'(err),        32'(vecs[i].er));
      if (vecs[i].we)
        check($sformatf("v%0d.mem_wdata", i), mem_wdata, vecs[i].data);
    end

    @(negedge clk);
    idle_inputs();
    #1;
    check("mem[100]",  tmem[100],  32'h8C010020);
    check("mem[101]",  tmem[101],  32'h8C100021);
    check("mem[102]",  tmem[102],  32'h00001024);
    check("mem[103]",  tmem[103],  init_pat(103));
    check("mem[5]",    tmem[5],    init_pat(5));
    check("mem[10]",   tmem[10],   32'h00000000);
    check("mem[1021]", tmem[1021], 32'h000000A1);
    check("mem[1022]", tmem[1022], 32'h000000A2);
    check("mem[1023]", tmem[1023], 32'h000000A3);
    check("mem[0]",    tmem[0],    init_pat(0));

    // Asynchronous reset after the first of three words.
    @(negedge clk);
    ld_start = 1'b1; ld_base = 10'd200; ld_count = 10'd3; if_adr = 10'd60;
    @(negedge clk);
    idle_inputs();
    ld_valid = 1'b1; ld_data = 32'h000000C1;
    #1;
    check("rstseq.ld_ready_pre", 32'(ld_ready), 32'd1);
    check("rstseq.mem_adr_pre",  32'(mem_adr),  32'd200);
    @(posedge clk);
    #3;
    ld_data = 32'h000000C2;
    rst = 1'b1;
    #1;
    check("rstseq.core_rst",   32'(core_rst),   32'd1);
    check("rstseq.ld_ready",   32'(ld_ready),   32'd0);
    check("rstseq.mem_we",     32'(mem_we),     32'd0);
    check("rstseq.busy",       32'(busy),       32'd0);
    check("rstseq.core_stall", 32'(core_stall), 32'd0);
    check("rstseq.mem_adr",    32'(mem_adr),    32'd60);
    @(negedge clk);
    rst = 1'b0;
    ld_data = 32'h000000C3;
    #1;
    check("rstseq.post_ready", 32'(ld_ready), 32'd0);
    check("rstseq.post_crst",  32'(core_rst), 32'd1);
    @(negedge clk);
    #1;
    check("rstseq.post_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("rstseq.mem[200]", tmem[200], 32'h000000C1);
    check("rstseq.mem[201]", tmem[201], init_pat(201));
    check("rstseq.mem[202]", tmem[202], init_pat(202));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Load controller that owns the single address port of the instruction memory and sequences it between program loading and instruction fetch. After reset it holds the core in reset, streams a program from a host/bench word-stream into instruction memory at a chosen base, drains, and then releases the core. While the core is running it also accepts "patch" loads: the core is stalled rather than reset, and the patched words are written in place. It sits between the IF stage (PC) and the instruction memory.

## Interface
- `ADDR_W`, default `` `ADDRESS_LEN ``: address width.
- `WORD_W`, default `` `WORD_LEN ``: instruction word width.
- `MEM_DEPTH`, default `` `MEMORY_SIZE ``: number of instruction words.
- `DRAIN_CYCLES`, default 4: post-load hold cycles, 1..15.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `ld_start  in  1`: one-cycle load request.
- `ld_keep  in  1`: sampled with `ld_start`. 1 selects a patch (stall core). 0 selects a full load (reset core).
- `ld_base  in  ADDR_W`: first word address, sampled on `ld_start`.
- `ld_count  in  ADDR_W`: number of words, sampled on `ld_start`.
- `ld_valid  in  1`: host word valid.
- `ld_data  in  WORD_W`: host word.
- `ld_ready  out  1`: controller accepts a word.
- `if_adr  in  ADDR_W`: fetch address from PC.
- `mem_adr  out  ADDR_W`: instruction memory address.
- `mem_we  out  1`: instruction memory write enable. The write commits on the `clk` rising edge.
- `mem_wdata  out  WORD_W`: instruction memory write data.
- `core_rst  out  1`: holds the pipeline and PC in reset.
- `core_stall  out  1`: freezes PC and pipeline registers.
- `busy  out  1`: high in LOAD or DRAIN.
- `done  out  1`: one-cycle pulse when a load completes.
- `err  out  1`: sticky flag for a rejected range.

## Operation
- **States:** BOOT, LOAD, DRAIN, RUN.
- **Reset values:**
  - State is BOOT.
  - `core_rst` = 1.
  - `core_stall`, `ld_ready`, `mem_we`, `busy`, `done`, `err` = 0.
  - Write pointer and remaining count are 0.
  - Mode is full.
- **BOOT:** `core_rst` = 1. Accepts `ld_start`. In BOOT, `ld_keep` is ignored and the load is always full.
- **RUN:** `core_rst` = 0 and `core_stall` = 0. Accepts `ld_start`; `ld_keep` selects full or patch mode.
- **Range check at `ld_start`:** compute `ld_base + ld_count` at ADDR_W+1 bits (no wrap).
  - If the sum exceeds MEM_DEPTH: set `err`, stay in the current state, perform no writes, assert no `done`.
  - Otherwise: clear `err`, load the pointer with `ld_base` and the remaining count with `ld_count`, latch the mode, and go to LOAD.
- **LOAD:**
  - `ld_ready` = 1.
  - On `ld_valid && ld_ready`:
    - `mem_we` = 1, `mem_adr` = pointer, `mem_wdata` = `ld_data` (combinational).
    - Pointer increments and remaining count decrements.
  - When the last word is accepted, go to DRAIN.
  - If `ld_count` = 0, LOAD lasts one cycle with `ld_ready` = 0 and no writes, then DRAIN.
- **DRAIN:** a down-counter runs for DRAIN_CYCLES cycles, then the state goes to RUN with `done` = 1 for that first RUN cycle.
- **Core control by mode:**
  - Full mode: `core_rst` = 1 throughout LOAD and DRAIN.
  - Patch mode: `core_stall` = 1 and `core_rst` = 0 throughout LOAD and DRAIN.
- **`mem_adr` outside LOAD:** equals `if_adr`.
- **`ld_start` during LOAD or DRAIN:** ignored; it does not set `err` and does not modify the sampled registers.
- **`ld_valid` outside LOAD:** ignored, because `ld_ready` = 0.
- **`rst` mid-operation:** all state and outputs return to reset values immediately, without a clock edge. Unwritten words are lost and memory contents already written are kept.

## Timing
- `ld_start` sampled at edge N: `ld_ready` = 1 from cycle N+1.
- Write latency is 0. The accepted word is written at the same edge where the handshake is seen.
- Last word accepted at edge M:
  - DRAIN covers cycles M+1 .. M+DRAIN_CYCLES.
  - RUN begins at cycle M+DRAIN_CYCLES+1, with `done` high and `core_rst`/`core_stall` low in that same cycle.
- Full-load throughput is 1 word per cycle when `ld_valid` is held high.
- `busy` is a registered state decode and is asserted from cycle N+1.
- `err` is registered, asserted at N+1, and stays set until the next in-range `ld_start` or `rst`.

## Structure
- Add the state encoding (`` `LDC_BOOT ``, `` `LDC_LOAD ``, `` `LDC_DRAIN ``, `` `LDC_RUN ``) and the default DRAIN_CYCLES to `configs.v`. Do not add anything else there.
- One sub-module, `load_addr_gen`: holds the write pointer and remaining-count registers. It has load, advance and last-word outputs.
- The FSM, drain counter and address mux stay in the top module.

## Test plan
- Reset, then `ld_start` with base=100, count=3, words 0x8C010020, 0x8C100021, 0x00001024 with one idle gap:
  - Writes land at addresses 100, 101, 102.
  - `done` pulses 4 cycles after the last accept.
  - `core_rst` falls in the same cycle as `done`.
  - `mem_adr` then tracks `if_adr`.
- count=0 with base=5: no `mem_we`, `done` 5 cycles after LOAD entry, core released.
- base=MEM_DEPTH-2 with count=3: `err` = 1 at N+1, no writes, state stays BOOT, `ld_ready` = 0.
- In RUN, `ld_keep`=1, base=10, count=1, word 0x00000000:
  - `core_stall` is high through LOAD and DRAIN.
  - `core_rst` stays 0.
  - A single write lands at 10.
  - `done` pulses and `core_stall` drops.
- `rst` asserted mid-cycle after 1 of 3 words:
  - `core_rst` = 1 and `ld_ready` = 0 immediately.
  - Later words are not written.
- `ld_start` pulsed again during LOAD with base=0: ignored, writes continue at the original pointer, `err` stays 0.
